lcd_status_reader: RTL and testbench

Read-side companion to the LCD character-display writer. It runs the HD44780 "read busy flag / address counter" bus cycle (RS=0, RW=1) on the shared 8-bit LCD data bus. It samples DB7 as the busy flag and DB6..DB0 as the address counter, and can optionally poll until the controller reports not-busy. It sits beside the LCD writer in the top level; the top level uses `owns_bus` to tristate `LCD_DATA` and to mux `LCD_RS`/`LCD_RW`/`LCD_EN` between the two blocks.

---
 rtl/lcd_status_reader.sv | 170 +++++++++++++++++
 tb/tb_lcd_status_reader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_status_reader.sv
// HD44780 busy-flag / address-counter reader: runs RS=0, RW=1 read cycles on the
// shared LCD bus and optionally repeats them until the controller reports not-busy.
module lcd_status_reader #(
    parameter int SETUP_CYCLES   = 2,
    parameter int EN_HIGH_CYCLES = 25,
    parameter int HOLD_CYCLES    = 2,
    parameter int GAP_CYCLES     = 25,
    parameter int MAX_POLLS      = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       poll,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       owns_bus,
    output logic       ready,
    output logic       done,
    output logic       busy_flag,
    output logic [6:0] addr_counter,
    output logic       timeout
);

    localparam int MAX_AB    = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES : EN_HIGH_CYCLES;
    localparam int MAX_CD    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_PHASE = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W     = $clog2(MAX_PHASE + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       SETUP_LAST = cnt_t'(SETUP_CYCLES - 1);
    localparam cnt_t       EN_LAST    = cnt_t'(EN_HIGH_CYCLES - 1);
    localparam cnt_t       HOLD_LAST  = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t       GAP_LAST   = cnt_t'(GAP_CYCLES - 1);
    localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HIGH,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    cnt_t       count_reg, count_next;
    logic       poll_mode_reg, poll_mode_next;
    logic [7:0] poll_cnt_reg, poll_cnt_next;
    logic       busy_flag_reg, busy_flag_next;
    logic [6:0] addr_reg, addr_next;
    logic       timeout_reg, timeout_next;
    logic       lcd_en_reg, lcd_en_next;
    logic       lcd_rw_reg, lcd_rw_next;
    logic       owns_bus_reg, owns_bus_next;
    logic       ready_reg, ready_next;
    logic       done_reg, done_next;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg + cnt_t'(1);
        poll_mode_next = poll_mode_reg;
        poll_cnt_next  = poll_cnt_reg;
        busy_flag_next = busy_flag_reg;
        addr_next      = addr_reg;
        timeout_next   = timeout_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                count_next = '0;
                state_next = S_IDLE;
                if (start) begin
                    state_next     = S_SETUP;
                    poll_mode_next = poll;
                    poll_cnt_next  = '0;
                end
            end
            S_SETUP: begin
                if (count_reg == SETUP_LAST) begin
                    state_next = S_EN_HIGH;
                    count_next = '0;
                end
            end
            S_EN_HIGH: begin
                // Sample on the edge that ends the strobe, while data is still valid.
                if (count_reg == EN_LAST) begin
                    state_next     = S_HOLD;
                    count_next     = '0;
                    busy_flag_next = lcd_data_in[7];
                    addr_next      = lcd_data_in[6:0];
                    if (poll_cnt_reg < POLL_LIMIT) begin
                        poll_cnt_next = poll_cnt_reg + 8'd1;
                    end
                end
            end
            S_HOLD: begin
                if (count_reg == HOLD_LAST) begin
                    count_next = '0;
                    if (poll_mode_reg && busy_flag_reg && (poll_cnt_reg < POLL_LIMIT)) begin
                        state_next = S_GAP;
                    end else begin
                        state_next   = S_DONE;
                        timeout_next = poll_mode_reg && busy_flag_reg;
                    end
                end
            end
            S_GAP: begin
                if (count_reg == GAP_LAST) begin
                    state_next = S_SETUP;
                    count_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase

        // Pin outputs are decoded from the next state so they come straight off flops.
        lcd_en_next   = (state_next == S_EN_HIGH);
        owns_bus_next = (state_next == S_SETUP) || (state_next == S_EN_HIGH) ||
                        (state_next == S_HOLD)  || (state_next == S_GAP);
        lcd_rw_next   = owns_bus_next;
        ready_next    = (state_next == S_IDLE) || (state_next == S_DONE);
        done_next     = (state_next == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            poll_mode_reg <= 1'b0;
            poll_cnt_reg  <= '0;
            busy_flag_reg <= 1'b0;
            addr_reg      <= '0;
            timeout_reg   <= 1'b0;
            lcd_en_reg    <= 1'b0;
            lcd_rw_reg    <= 1'b0;
            owns_bus_reg  <= 1'b0;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            poll_mode_reg <= poll_mode_next;
            poll_cnt_reg  <= poll_cnt_next;
            busy_flag_reg <= busy_flag_next;
            addr_reg      <= addr_next;
            timeout_reg   <= timeout_next;
            lcd_en_reg    <= lcd_en_next;
            lcd_rw_reg    <= lcd_rw_next;
            owns_bus_reg  <= owns_bus_next;
            ready_reg     <= ready_next;
            done_reg      <= done_next;
        end
    end

    assign lcd_rs       = 1'b0;
    assign lcd_rw       = lcd_rw_reg;
    assign lcd_en       = lcd_en_reg;
    assign owns_bus     = owns_bus_reg;
    assign ready        = ready_reg;
    assign done         = done_reg;
    assign busy_flag    = busy_flag_reg;
    assign addr_counter = addr_reg;
    assign timeout      = timeout_reg;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: table vectors, randomized poll sequences against a
// read-count model, and hand sequences for reset and start-handling corners.
`timescale 1ns/1ps
module tb_lcd_status_reader;

    localparam int S        = 2;
    localparam int E        = 25;
    localparam int H        = 2;
    localparam int G        = 25;
    localparam int MAXA     = 255;
    localparam int MAXB     = 4;
    localparam int READ_LAT = 1 + S + E + H;
    localparam int POLL_LAT = G + S + E + H;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       poll = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;

    logic       rs_a, rw_a, en_a, owns_a, ready_a, done_a, busy_a, to_a;
    logic [6:0] addr_a;
    logic       rs_b, rw_b, en_b, owns_b, ready_b, done_b, busy_b, to_b;
    logic [6:0] addr_b;

    always #10 clock = ~clock;

    lcd_status_reader dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .poll(poll),
        .lcd_data_in(lcd_data_in), .lcd_rs(rs_a), .lcd_rw(rw_a), .lcd_en(en_a),
        .owns_bus(owns_a), .ready(ready_a), .done(done_a), .busy_flag(busy_a),
        .addr_counter(addr_a), .timeout(to_a)
    );

    lcd_status_reader #(.MAX_POLLS(MAXB)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .poll(poll),
        .lcd_data_in(lcd_data_in), .lcd_rs(rs_b), .lcd_rw(rw_b), .lcd_en(en_b),
        .owns_bus(owns_b), .ready(ready_b), .done(done_b), .busy_flag(busy_b),
        .addr_counter(addr_b), .timeout(to_b)
    );

    bit         cur_sel = 1'b0;
    logic       m_en, m_rw, m_rs, m_owns, m_done, m_busy, m_to, m_ready;
    logic [6:0] m_addr;

    always_comb begin
        if (cur_sel) begin
            m_en = en_b; m_rw = rw_b; m_rs = rs_b; m_owns = owns_b; m_done = done_b;
            m_busy = busy_b; m_to = to_b; m_ready = ready_b; m_addr = addr_b;
        end else begin
            m_en = en_a; m_rw = rw_a; m_rs = rs_a; m_owns = owns_a; m_done = done_a;
            m_busy = busy_a; m_to = to_a; m_ready = ready_a; m_addr = addr_a;
        end
    end

    typedef struct {
        bit         sel;
        bit         poll;
        logic [7:0] d0, d1, d2, d3;
        int         pulses;
        int         lat;
        int         busy;
        int         addr;
        int         to;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] rd_data [8];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input bit v);
        if (cur_sel) start_b = v;
        else start_a = v;
    endtask

    // Reference: number of reads and final sample follow from the busy-flag rule alone.
    task automatic model(input bit p, input int maxp, output int n, output int fin, output int to);
        logic [7:0] v;
        n = p ? maxp : 1;
        if (p) begin
            for (int i = 0; i < maxp; i++) begin
                v = rd_data[(i > 7) ? 7 : i];
                if (!v[7]) begin
                    n = i + 1;
                    break;
                end
            end
        end
        v = rd_data[((n - 1) > 7) ? 7 : (n - 1)];
        fin = int'(v);
        to = int'(p && v[7]);
    endtask

    task automatic run_req(input bit sel, input bit p, input bit now, input int extra_at,
                           output int lat, output int pulses, output int en_lo, output int en_hi,
                           output int pre_rw, output int post_rw, output int first_owns);
        int en_len;
        bit prev_en;
        if (!now) @(negedge clock);
        cur_sel = sel;
        poll = p;
        set_start(1'b1);
        lat = -1; pulses = 0; en_len = 0; en_lo = 1000; en_hi = 0;
        pre_rw = 0; post_rw = 0; first_owns = -1; prev_en = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(posedge clock);
            #1;
            set_start(cyc == extra_at);
            if (cyc == 1) begin
                first_owns = int'(m_owns);
                poll = 1'($urandom_range(0, 1));
            end
            if (m_en && !prev_en) begin
                pulses++;
                en_len = 0;
                lcd_data_in = rd_data[((pulses - 1) > 7) ? 7 : (pulses - 1)];
            end
            if (m_en) en_len++;
            if (!m_en && prev_en) begin
                if (en_len < en_lo) en_lo = en_len;
                if (en_len > en_hi) en_hi = en_len;
                lcd_data_in = 8'($urandom);
                post_rw = 0;
            end
            if (pulses == 0 && m_rw && !m_rs && !m_en) pre_rw++;
            if (pulses > 0 && m_rw && !m_en) post_rw++;
            prev_en = m_en;
            if (m_done) begin
                lat = cyc;
                break;
            end
        end
        set_start(1'b0);
    endtask

    task automatic apply(input string name, input bit sel, input bit p, input int e_pulses,
                         input int e_lat, input int e_busy, input int e_addr, input int e_to);
        int lat, pulses, en_lo, en_hi, pre_rw, post_rw, fo;
        run_req(sel, p, 1'b0, 0, lat, pulses, en_lo, en_hi, pre_rw, post_rw, fo);
        $display("%s: sel=%0d poll=%0d lat=%0d pulses=%0d busy=%0d addr=%02h timeout=%0d",
                 name, sel, p, lat, pulses, m_busy, m_addr, m_to);
        check({name, " latency"}, lat, e_lat);
        check({name, " pulses"}, pulses, e_pulses);
        check({name, " en_min"}, en_lo, E);
        check({name, " en_max"}, en_hi, E);
        check({name, " rw_setup"}, pre_rw, S);
        check({name, " rw_hold"}, post_rw, H);
        check({name, " busy"}, int'(m_busy), e_busy);
        check({name, " addr"}, int'(m_addr), e_addr);
        check({name, " timeout"}, int'(m_to), e_to);
        check({name, " done_ready"}, int'(m_ready), 1);
        check({name, " done_owns"}, int'(m_owns), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pulses, en_lo, en_hi, pre_rw, post_rw, fo, n, fin, to, extra;
        bit sel, p;
        string nm;

        tbl[0] = '{0, 0, 8'h85, 8'h85, 8'h85, 8'h85, 1, READ_LAT, 1, 8'h05, 0};
        tbl[1] = '{0, 1, 8'h80, 8'h80, 8'h80, 8'h12, 4, READ_LAT + 3 * POLL_LAT, 0, 8'h12, 0};
        tbl[2] = '{1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4, READ_LAT + 3 * POLL_LAT, 1, 8'h7F, 1};
        tbl[3] = '{0, 1, 8'h3A, 8'h80, 8'h80, 8'h80, 1, READ_LAT, 0, 8'h3A, 0};
        tbl[4] = '{1, 1, 8'h81, 8'h82, 8'h83, 8'h04, 4, READ_LAT + 3 * POLL_LAT, 0, 8'h04, 0};
        tbl[5] = '{0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 1, READ_LAT, 1, 8'h7F, 0};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset ready", int'(ready_a), 1);
        check("reset done", int'(done_a), 0);
        check("reset en", int'(en_a), 0);
        check("reset rw", int'(rw_a), 0);
        check("reset owns", int'(owns_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset addr", int'(addr_a), 0);
        check("reset timeout", int'(to_a), 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            rd_data[0] = tbl[i].d0;
            rd_data[1] = tbl[i].d1;
            rd_data[2] = tbl[i].d2;
            for (int j = 3; j < 8; j++) rd_data[j] = tbl[i].d3;
            nm = $sformatf("vec%0d", i);
            apply(nm, tbl[i].sel, tbl[i].poll, tbl[i].pulses, tbl[i].lat,
                  tbl[i].busy, tbl[i].addr, tbl[i].to);
        end

        for (int r = 0; r < 20; r++) begin
            sel = 1'($urandom_range(0, 1));
            p = 1'($urandom_range(0, 1));
            for (int j = 0; j < 8; j++) begin
                rd_data[j] = {($urandom_range(0, 3) != 0), 7'($urandom)};
            end
            rd_data[7][7] = 1'b0;
            model(p, sel ? MAXB : MAXA, n, fin, to);
            nm = $sformatf("rnd%0d", r);
            apply(nm, sel, p, n, READ_LAT + (n - 1) * POLL_LAT, fin / 128, fin % 128, to);
        end

        // Start during EN_HIGH is dropped, not queued
        for (int j = 0; j < 8; j++) rd_data[j] = 8'h2A;
        run_req(1'b0, 1'b0, 1'b0, 12, lat, pulses, en_lo, en_hi, pre_rw, post_rw, fo);
        $display("start_in_en: lat=%0d pulses=%0d", lat, pulses);
        check("start_in_en latency", lat, READ_LAT);
        check("start_in_en pulses", pulses, 1);
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock);
            #1;
            if (done_a || en_a) extra++;
        end
        check("start_in_en extra_activity", extra, 0);

        // Start in the DONE cycle chains straight into SETUP
        run_req(1'b0, 1'b0, 1'b0, 0, lat, pulses, en_lo, en_hi, pre_rw, post_rw, fo);
        check("chain first latency", lat, READ_LAT);
        check("chain done owns", int'(owns_a), 0);
        run_req(1'b0, 1'b0, 1'b1, 0, lat, pulses, en_lo, en_hi, pre_rw, post_rw, fo);
        $display("chain: second lat=%0d first_owns=%0d pulses=%0d", lat, fo, pulses);
        check("chain second owns", fo, 1);
        check("chain second latency", lat, READ_LAT);
        check("chain second pulses", pulses, 1);

        // Reset in the 10th EN_HIGH cycle
        @(negedge clock);
        cur_sel = 1'b0;
        lcd_data_in = 8'hD5;
        poll = 1'b0;
        start_a = 1'b1;
        @(posedge clock);
        #1;
        start_a = 1'b0;
        lat = -1;
        for (int c = 0; c < 100; c++) begin
            if (en_a) begin
                lat = c;
                break;
            end
            @(posedge clock);
            #1;
        end
        check("midreset en_seen", int'(lat >= 0), 1);
        repeat (9) @(posedge clock);
        #5;
        reset_n = 1'b0;
        #1;
        $display("midreset: en=%0d rw=%0d owns=%0d busy=%0d addr=%02h", en_a, rw_a, owns_a, busy_a, addr_a);
        check("midreset en", int'(en_a), 0);
        check("midreset rw", int'(rw_a), 0);
        check("midreset owns", int'(owns_a), 0);
        check("midreset ready", int'(ready_a), 1);
        check("midreset busy", int'(busy_a), 0);
        check("midreset addr", int'(addr_a), 0);
        check("midreset timeout", int'(to_a), 0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (done_a || en_a) extra++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock);
            #1;
            if (done_a || en_a) extra++;
        end
        check("midreset no_done", extra, 0);
        for (int j = 0; j < 8; j++) rd_data[j] = 8'h91;
        apply("after_reset", 1'b0, 1'b0, 1, READ_LAT, 1, 8'h11, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
